renode_axi_memory: RTL and testbench

- AXI4 slave memory (subordinate), byte-addressable, for the co-simulation testbench.
- Sits behind an AXI manager, which drives requests translated from bus-controller read/write calls (Byte/Word/DoubleWord/QuadWord).
- Serves single-beat and burst reads and writes from an internal RAM array and returns AXI responses.
- Read and write channels are independent, with one outstanding transaction per direction.

---
 rtl/renode_axi_memory.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_renode_axi_memory.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renode_axi_memory.sv
// AXI4 subordinate memory for co-simulation: independent read/write FSMs, one
// outstanding transaction per direction, FIXED/INCR/WRAP bursts, OKAY/SLVERR/DECERR.
module renode_axi_memory #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       MEM_BYTES = 65536
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [7:0]        aw_len,
    input  logic [2:0]        aw_size,
    input  logic [1:0]        aw_burst,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic              w_last,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp,
    output logic              b_valid,
    input  logic              b_ready,
    input  logic [ID_W-1:0]   ar_id,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [7:0]        ar_len,
    input  logic [2:0]        ar_size,
    input  logic [1:0]        ar_burst,
    input  logic              ar_valid,
    output logic              ar_ready,
    output logic [ID_W-1:0]   r_id,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic              r_valid,
    input  logic              r_ready
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned LANE_BITS = $clog2(STRB_W);
    localparam int unsigned WORDS     = MEM_BYTES / STRB_W;
    localparam int unsigned WORD_AW   = $clog2(WORDS);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Zero at time 0; deliberately untouched by rst_i.
    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < MEM_LIMIT);
    endfunction

    function automatic logic [WORD_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE_ADDR) >> LANE_BITS;
        return WORD_AW'(off);
    endfunction

    function automatic logic [1:0] txn_err(input logic [2:0] size, input logic [7:0] len,
                                           input logic [1:0] burst);
        logic bad;
        bad = (size > 3'(LANE_BITS)) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        return bad ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [2:0] size, input logic [7:0] len,
                                                     input logic [1:0] burst);
        logic [ADDR_W-1:0] incr, mask;
        incr = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        unique case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + incr) & mask);
            default: return a + incr;
        endcase
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Write path
    w_state_e          w_state_q, w_state_d;
    logic              aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic [1:0]        b_resp_q, b_resp_d, werr_q, werr_d, wworst_q, wworst_d;
    logic [ID_W-1:0]   b_id_q, b_id_d, wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              mem_we;
    logic [1:0]        w_beat_resp, w_worst;
    logic              w_at_len;

    always_comb begin
        w_state_d   = w_state_q;
        aw_ready_d  = aw_ready_q;
        w_ready_d   = w_ready_q;
        b_valid_d   = b_valid_q;
        b_resp_d    = b_resp_q;
        b_id_d      = b_id_q;
        wid_d       = wid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        werr_d      = werr_q;
        wcnt_d      = wcnt_q;
        wworst_d    = wworst_q;
        mem_we      = 1'b0;
        w_beat_resp = in_range(waddr_q) ? werr_q : RESP_DECERR;
        w_worst     = resp_max(wworst_q, w_beat_resp);
        w_at_len    = (wcnt_q == wlen_q);
        unique case (w_state_q)
            WIdle: begin
                if (aw_valid && aw_ready_q) begin
                    wid_d      = aw_id;
                    waddr_d    = aw_addr;
                    wlen_d     = aw_len;
                    wsize_d    = aw_size;
                    wburst_d   = aw_burst;
                    werr_d     = txn_err(aw_size, aw_len, aw_burst);
                    wworst_d   = RESP_OKAY;
                    wcnt_d     = 8'd0;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_state_d  = WData;
                end
            end
            WData: begin
                if (w_valid && w_ready_q) begin
                    // A beat in flight when rst_i hits is dropped along with the burst.
                    mem_we   = (w_beat_resp == RESP_OKAY) && !rst_i;
                    waddr_d  = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                    wcnt_d   = wcnt_q + 8'd1;
                    wworst_d = w_worst;
                    if (w_at_len || w_last) begin
                        b_resp_d  = (w_at_len != w_last) ? resp_max(w_worst, RESP_SLVERR)
                                                         : w_worst;
                        b_valid_d = 1'b1;
                        b_id_d    = wid_q;
                        w_ready_d = 1'b0;
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (b_ready) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_state_d  = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q  <= WIdle;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            b_id_q     <= '0;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            werr_q     <= RESP_OKAY;
            wcnt_q     <= '0;
            wworst_q   <= RESP_OKAY;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            b_id_q     <= b_id_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            werr_q     <= werr_d;
            wcnt_q     <= wcnt_d;
            wworst_q   <= wworst_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    // Read path
    r_state_e          r_state_q, r_state_d;
    logic              ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d, rerr_q, rerr_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_err, rd_resp;

    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_id_d     = r_id_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rerr_d     = rerr_q;
        rcnt_d     = rcnt_q;
        rd_load    = 1'b0;
        rd_addr    = raddr_q;
        rd_err     = rerr_q;
        unique case (r_state_q)
            RIdle: begin
                if (ar_valid && ar_ready_q) begin
                    r_id_d     = ar_id;
                    raddr_d    = ar_addr;
                    rlen_d     = ar_len;
                    rsize_d    = ar_size;
                    rburst_d   = ar_burst;
                    rerr_d     = txn_err(ar_size, ar_len, ar_burst);
                    rcnt_d     = 8'd0;
                    r_last_d   = (ar_len == 8'd0);
                    r_valid_d  = 1'b1;
                    ar_ready_d = 1'b0;
                    rd_load    = 1'b1;
                    rd_addr    = ar_addr;
                    rd_err     = rerr_d;
                    r_state_d  = RData;
                end
            end
            RData: begin
                if (r_ready) begin
                    if (r_last_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        r_state_d  = RIdle;
                    end else begin
                        rd_addr  = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                        raddr_d  = rd_addr;
                        rcnt_d   = rcnt_q + 8'd1;
                        r_last_d = ((rcnt_q + 8'd1) == rlen_q);
                        rd_load  = 1'b1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
        rd_resp = in_range(rd_addr) ? rd_err : RESP_DECERR;
        if (rd_load) begin
            r_resp_d = rd_resp;
            r_data_d = (rd_resp == RESP_OKAY) ? mem[word_idx(rd_addr)] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q  <= RIdle;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_id_q     <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rerr_q     <= RESP_OKAY;
            rcnt_q     <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_id_q     <= r_id_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
            rerr_q     <= rerr_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;
    assign b_id     = b_id_q;
    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_last   = r_last_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_id     = r_id_q;

endmodule

// File: tb/tb_renode_axi_memory.sv
// Directed bench for renode_axi_memory (64-bit data, 64 KiB at base 0).
module tb_renode_axi_memory;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [63:0] w_data, r_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    renode_axi_memory dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid),
        .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string what);
        tests_run++;
        tests_failed++;
        $display("FAIL timeout %s: handshake never completed", what);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        aw_valid = 1'b1;
        while (!aw_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("aw");
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
        while (!w_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("w");
        tick();
        w_valid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        b_ready = 1'b1;
        while (!b_valid && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("b");
        resp = b_resp; id = b_id;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        ar_valid = 1'b1;
        while (!ar_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("ar");
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic read_beat(output logic [63:0] d, output logic [1:0] resp,
                             output logic last, output logic [3:0] id);
        int n = 0;
        r_ready = 1'b1;
        while (!r_valid && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("r");
        d = r_data; resp = r_resp; last = r_last; id = r_id;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        tests_run += 11;
        if (aw_ready !== 1'b1) begin tests_failed++; $display("FAIL rst aw_ready got %b want 1", aw_ready); end
        if (ar_ready !== 1'b1) begin tests_failed++; $display("FAIL rst ar_ready got %b want 1", ar_ready); end
        if (w_ready !== 1'b0) begin tests_failed++; $display("FAIL rst w_ready got %b want 0", w_ready); end
        if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL rst b_valid got %b want 0", b_valid); end
        if (r_valid !== 1'b0) begin tests_failed++; $display("FAIL rst r_valid got %b want 0", r_valid); end
        if (r_last !== 1'b0) begin tests_failed++; $display("FAIL rst r_last got %b want 0", r_last); end
        if (b_resp !== 2'b00) begin tests_failed++; $display("FAIL rst b_resp got %b want 00", b_resp); end
        if (r_resp !== 2'b00) begin tests_failed++; $display("FAIL rst r_resp got %b want 00", r_resp); end
        if (r_data !== 64'h0) begin tests_failed++; $display("FAIL rst r_data got %h want 0", r_data); end
        if (b_id !== 4'h0) begin tests_failed++; $display("FAIL rst b_id got %h want 0", b_id); end
        if (r_id !== 4'h0) begin tests_failed++; $display("FAIL rst r_id got %h want 0", r_id); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_read_unwritten();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
        do_ar(4'h1, 32'h1018, 8'd0, 3'd2, 2'b01);
        read_beat(d, rs, l, id);
        tests_run += 4;
        if (d !== 64'h0) begin tests_failed++; $display("FAIL unwr data got %h want 0", d); end
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL unwr resp got %b want 00", rs); end
        if (l !== 1'b1) begin tests_failed++; $display("FAIL unwr last got %b want 1", l); end
        if (id !== 4'h1) begin tests_failed++; $display("FAIL unwr r_id got %h want 1", id); end
        do_ar(4'h1, 32'h101A, 8'd0, 3'd1, 2'b01);
        read_beat(d, rs, l, id);
        tests_run += 2;
        if (d !== 64'h0) begin tests_failed++; $display("FAIL unwr16 data got %h want 0", d); end
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL unwr16 resp got %b want 00", rs); end
    endtask

    task automatic test_single_write();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
        do_aw(4'h2, 32'h10C0, 8'd0, 3'd2, 2'b01);
        do_w(64'hDEAD_BEEF_0000_0100, 8'h0F, 1'b1);
        wait_b(rs, id);
        tests_run += 2;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL w32 b_resp got %b want 00", rs); end
        if (id !== 4'h2) begin tests_failed++; $display("FAIL w32 b_id got %h want 2", id); end
        do_ar(4'h2, 32'h10C0, 8'd0, 3'd2, 2'b01);
        read_beat(d, rs, l, id);
        tests_run += 2;
        // Upper lanes were masked by strb so must still read zero.
        if (d !== 64'h0000_0000_0000_0100) begin tests_failed++; $display("FAIL w32 data got %h want 100", d); end
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL w32 r_resp got %b want 00", rs); end
        do_aw(4'h3, 32'h1000, 8'd0, 3'd3, 2'b01);
        do_w(64'h0000_0000_0000_0200, 8'hFF, 1'b1);
        wait_b(rs, id);
        tests_run++;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL w64 b_resp got %b want 00", rs); end
        do_ar(4'h3, 32'h1000, 8'd0, 3'd3, 2'b01);
        read_beat(d, rs, l, id);
        tests_run++;
        if (d !== 64'h200) begin tests_failed++; $display("FAIL w64 data got %h want 200", d); end
    endtask

    task automatic test_incr_burst();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
        logic [63:0] exp_d [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
        do_aw(4'h5, 32'h2000, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(exp_d[i], 8'hFF, i == 3);
        wait_b(rs, id);
        tests_run += 2;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL incr b_resp got %b want 00", rs); end
        if (id !== 4'h5) begin tests_failed++; $display("FAIL incr b_id got %h want 5", id); end
        do_ar(4'h9, 32'h2000, 8'd3, 3'd3, 2'b01);
        read_beat(d, rs, l, id);
        tests_run += 3;
        if (d !== 64'h11) begin tests_failed++; $display("FAIL incr beat0 got %h want 11", d); end
        if (l !== 1'b0) begin tests_failed++; $display("FAIL incr last0 got %b want 0", l); end
        if (id !== 4'h9) begin tests_failed++; $display("FAIL incr r_id got %h want 9", id); end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (!(r_valid === 1'b1 && r_data === 64'h22 && r_last === 1'b0)) begin
                tests_failed++;
                $display("FAIL incr hold%0d got v=%b d=%h l=%b want v=1 d=22 l=0", c, r_valid, r_data, r_last);
            end
        end
        for (int i = 1; i < 4; i++) begin
            read_beat(d, rs, l, id);
            tests_run += 2;
            if (d !== exp_d[i]) begin tests_failed++; $display("FAIL incr beat%0d got %h want %h", i, d, exp_d[i]); end
            if (l !== (i == 3)) begin tests_failed++; $display("FAIL incr last%0d got %b want %b", i, l, i == 3); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
        logic [63:0] exp_d [4] = '{64'h3, 64'h4, 64'h1, 64'h2};
        do_aw(4'h6, 32'h4010, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) do_w(64'(i + 1), 8'hFF, i == 3);
        wait_b(rs, id);
        tests_run++;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL wrap b_resp got %b want 00", rs); end
        do_ar(4'h6, 32'h4000, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            read_beat(d, rs, l, id);
            tests_run++;
            if (d !== exp_d[i]) begin tests_failed++; $display("FAIL wrap beat%0d got %h want %h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_errors();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
        do_ar(4'h7, 32'h0001_0000, 8'd0, 3'd3, 2'b01);
        read_beat(d, rs, l, id);
        tests_run += 2;
        if (rs !== 2'b11) begin tests_failed++; $display("FAIL decerr r_resp got %b want 11", rs); end
        if (d !== 64'h0) begin tests_failed++; $display("FAIL decerr r_data got %h want 0", d); end
        do_aw(4'h7, 32'h0001_0000, 8'd0, 3'd3, 2'b01);
        do_w(64'hFF, 8'hFF, 1'b1);
        wait_b(rs, id);
        tests_run++;
        if (rs !== 2'b11) begin tests_failed++; $display("FAIL decerr b_resp got %b want 11", rs); end
        do_ar(4'h7, 32'h0, 8'd0, 3'd3, 2'b01);
        read_beat(d, rs, l, id);
        tests_run++;
        if (d !== 64'h0) begin tests_failed++; $display("FAIL decerr alias got %h want 0", d); end
        do_ar(4'h8, 32'h1000, 8'd0, 3'd4, 2'b01);
        read_beat(d, rs, l, id);
        tests_run += 2;
        if (rs !== 2'b10) begin tests_failed++; $display("FAIL size r_resp got %b want 10", rs); end
        if (d !== 64'h0) begin tests_failed++; $display("FAIL size r_data got %h want 0", d); end
        do_ar(4'h8, 32'h1000, 8'd0, 3'd3, 2'b11);
        read_beat(d, rs, l, id);
        tests_run++;
        if (rs !== 2'b10) begin tests_failed++; $display("FAIL burst11 r_resp got %b want 10", rs); end
        do_aw(4'h8, 32'h5000, 8'd1, 3'd3, 2'b01);
        do_w(64'h55, 8'hFF, 1'b1);
        wait_b(rs, id);
        tests_run++;
        if (rs !== 2'b10) begin tests_failed++; $display("FAIL wlast b_resp got %b want 10", rs); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
        do_aw(4'h3, 32'h3000, 8'd3, 3'd3, 2'b01);
        do_w(64'hAA, 8'hFF, 1'b0);
        w_data = 64'hBB; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        w_valid = 1'b0;
        tick(); tick();
        tests_run += 3;
        if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst b_valid got %b want 0", b_valid); end
        if (aw_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst aw_ready got %b want 1", aw_ready); end
        if (w_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst w_ready got %b want 0", w_ready); end
        do_ar(4'h3, 32'h3000, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            read_beat(d, rs, l, id);
            if (i == 0) begin
                tests_run++;
                if (d !== 64'hAA) begin tests_failed++; $display("FAIL midrst beat0 got %h want aa", d); end
            end else if (i >= 2) begin
                tests_run++;
                if (d !== 64'h0) begin tests_failed++; $display("FAIL midrst beat%0d got %h want 0", i, d); end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
        w_data = '0; w_strb = '0; w_last = 1'b0;
        tick();
        test_reset();
        test_read_unwritten();
        test_single_write();
        test_incr_burst();
        test_wrap();
        test_errors();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
